branch_resolve_ctrl: RTL

Execute-stage controller that sequences each resolved branch through the branch unit result, detects mispredictions against the front-end prediction, and issues a single held redirect/flush to fetch. Every accepted branch also goes into a small predictor-update FIFO drained by the BTB/PHT. Sits between the execute-stage branch comparator and the fetch/predictor logic. It is the only source of branch-caused pipeline redirects.

---
 rtl/branch_resolve_ctrl_if.sv | 70 +++++++
 rtl/branch_resolve_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl_if.sv
// -----------------------------------------------------------------------------
// branch_resolve_pkg / branch_resolve_ctrl_if
//
// Purpose : Branch-op encoding shared by the execute stage and the branch
//           resolve controller, plus the interface bundling all of the
//           controller's handshake and data signals.
//
// Signal groups (directions as seen from the controller, i.e. modport slave):
//   ex_*     in  (ex_ready out)  resolved branch uop from the execute stage
//   redir_*  out (redir_ready in) held redirect request to fetch
//   flush    out                  one-cycle kill of younger uops
//   upd_*    out (upd_ready in)  predictor-update FIFO head
//   stat_*   out                  branch / mispredict counters
// The master modport is the environment side (execute, fetch, predictor).
// -----------------------------------------------------------------------------
package branch_resolve_pkg;
    typedef enum logic [3:0] {
        BRU_BEQ  = 4'd0,
        BRU_BNE  = 4'd1,
        BRU_BLT  = 4'd2,
        BRU_BLTU = 4'd3,
        BRU_BGE  = 4'd4,
        BRU_BGEU = 4'd5,
        BRU_B    = 4'd6,
        BRU_BL   = 4'd7,
        BRU_JIRL = 4'd8
    } bru_op_t;
endpackage

interface branch_resolve_ctrl_if;
    import branch_resolve_pkg::*;

    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    bru_op_t     ex_op;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;

    logic        redir_valid;
    logic        redir_ready;
    logic [31:0] redir_pc;
    logic        flush;

    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic [1:0]  upd_kind;

    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;

    modport master (
        output ex_valid, ex_pc, ex_op, ex_taken, ex_target, ex_pred_taken,
               ex_pred_target, redir_ready, upd_ready,
        input  ex_ready, redir_valid, redir_pc, flush, upd_valid, upd_pc,
               upd_target, upd_taken, upd_kind, stat_branches, stat_mispred
    );

    modport slave (
        input  ex_valid, ex_pc, ex_op, ex_taken, ex_target, ex_pred_taken,
               ex_pred_target, redir_ready, upd_ready,
        output ex_ready, redir_valid, redir_pc, flush, upd_valid, upd_pc,
               upd_target, upd_taken, upd_kind, stat_branches, stat_mispred
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// branch_resolve_ctrl
//
// Purpose : Execute-stage branch controller. Accepts resolved branches,
//           detects mispredictions against the front-end prediction, raises a
//           single held redirect plus a one-cycle flush, and queues every
//           accepted branch into a predictor-update FIFO.
//
// Ports   : clk  - core clock, rising edge
//           rst  - asynchronous, active-high reset
//           bus  - branch_resolve_ctrl_if.slave (ex_*, redir_*, flush, upd_*,
//                  stat_*)
//
// Parameter : UPD_DEPTH - update FIFO entries (power of two, >= 2)
//
// Build option : define BRANCH_STATS_EN to build the stat_branches /
//                stat_mispred counters; otherwise both outputs read 0.
// -----------------------------------------------------------------------------
module branch_resolve_ctrl
    import branch_resolve_pkg::*;
#(
    parameter int UPD_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_resolve_ctrl_if.slave bus
);

    localparam int PW = $clog2(UPD_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        ST_IDLE       = 1'b0,
        ST_WAIT_REDIR = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   redir_pc_q, redir_pc_d;
    logic          flush_q, flush_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    // FIFO payload storage; only the pointers/count need reset.
    logic [31:0] pc_mem     [UPD_DEPTH];
    logic [31:0] target_mem [UPD_DEPTH];
    logic        taken_mem  [UPD_DEPTH];
    logic [1:0]  kind_mem   [UPD_DEPTH];

    logic        op_legal;
    logic        ex_ready;
    logic        accept;
    logic        pop;
    logic        mispred;
    logic [31:0] correct_pc;
    logic [1:0]  kind;

    // Illegal encodings (9..15) are never accepted.
    assign op_legal = (4'(bus.ex_op) <= 4'(BRU_JIRL));
    assign ex_ready = (state_q == ST_IDLE) && (count_q < CW'(UPD_DEPTH)) && op_legal;
    assign accept   = bus.ex_valid && ex_ready;
    assign pop      = (count_q != '0) && bus.upd_ready;

    assign mispred    = (bus.ex_taken != bus.ex_pred_taken) ||
                        (bus.ex_taken && (bus.ex_target != bus.ex_pred_target));
    assign correct_pc = bus.ex_taken ? bus.ex_target : (bus.ex_pc + 32'd4);

    always_comb begin
        kind = 2'd0;
        case (bus.ex_op)
            BRU_B:    kind = 2'd1;
            BRU_BL:   kind = 2'd2;
            BRU_JIRL: kind = 2'd3;
            default:  kind = 2'd0;
        endcase
    end

    // Redirect FSM: one mispredict moves to WAIT_REDIR, where intake stalls
    // until fetch takes the redirect.
    always_comb begin
        state_d    = state_q;
        redir_pc_d = redir_pc_q;
        flush_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && mispred) begin
                    state_d    = ST_WAIT_REDIR;
                    redir_pc_d = correct_pc;
                    flush_d    = 1'b1;
                end
            end
            ST_WAIT_REDIR: begin
                if (bus.redir_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pointers wrap naturally because UPD_DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            redir_pc_q <= '0;
            flush_q    <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            redir_pc_q <= redir_pc_d;
            flush_q    <= flush_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pc_mem[wr_ptr_q]     <= bus.ex_pc;
            target_mem[wr_ptr_q] <= bus.ex_target;
            taken_mem[wr_ptr_q]  <= bus.ex_taken;
            kind_mem[wr_ptr_q]   <= kind;
        end
    end

    assign bus.ex_ready    = ex_ready;
    assign bus.redir_valid = (state_q == ST_WAIT_REDIR);
    assign bus.redir_pc    = redir_pc_q;
    assign bus.flush       = flush_q;
    assign bus.upd_valid   = (count_q != '0);
    assign bus.upd_pc      = pc_mem[rd_ptr_q];
    assign bus.upd_target  = target_mem[rd_ptr_q];
    assign bus.upd_taken   = taken_mem[rd_ptr_q];
    assign bus.upd_kind    = kind_mem[rd_ptr_q];

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispred_q, stat_mispred_d;

    always_comb begin
        stat_branches_d = stat_branches_q + 32'(accept);
        stat_mispred_d  = stat_mispred_q + 32'(accept && mispred);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign bus.stat_branches = stat_branches_q;
    assign bus.stat_mispred  = stat_mispred_q;
`else
    assign bus.stat_branches = 32'd0;
    assign bus.stat_mispred  = 32'd0;
`endif

    // An illegal op is held off forever, so flag it loudly in simulation.
    assert property (@(posedge clk) disable iff (rst) bus.ex_valid |-> op_legal)
        else $error("branch_resolve_ctrl: illegal ex_op %0d", bus.ex_op);

endmodule
